// File: rtl/bias_seq_pkg.sv
// Shared types, default widths and bias sign-magnitude decoding for the bias channel sequencer.
// Pure declarations: no latency, no flow control.
package bias_seq_pkg;

  localparam int DEF_N_CH  = 64;
  localparam int DEF_ACC_W = 24;
  localparam int DEF_PIX_W = 16;
  localparam int DEF_SHIFT = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  // 0x8000 (negative zero) decodes to 0 like any other zero magnitude.
  function automatic logic signed [16:0] sm_to_tc(input logic [15:0] sm);
    logic signed [16:0] mag;
    mag = signed'({2'b00, sm[14:0]});
    return sm[15] ? -mag : mag;
  endfunction

endpackage

// File: rtl/bias_postproc.sv
// Bias add, arithmetic shift, ReLU and 16-bit saturation of one accumulator value.
// Purely combinational (zero latency); no flow control of its own.
module bias_postproc
  import bias_seq_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic signed [ACC_W-1:0] acc_data,
  input  logic        [15:0]      bias_sm,
  output logic        [15:0]      result
);

  logic signed [16:0]    bias_tc;
  logic signed [ACC_W:0] bias_ext;
  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] shifted;

  assign bias_tc  = sm_to_tc(bias_sm);
  assign bias_ext = (ACC_W+1)'(bias_tc);
  assign sum      = (ACC_W+1)'(acc_data) + bias_ext;
  assign shifted  = sum >>> SHIFT;

  // Non-negative values with any bit at or above bit 15 exceed 32767.
  always_comb begin
    result = shifted[15:0];
    if (shifted[ACC_W]) begin
      result = '0;
    end else if (|shifted[ACC_W-1:15]) begin
      result = 16'h7FFF;
    end
  end

endmodule

// File: rtl/bias_channel_sequencer.sv
// Walks N_CH channels per pixel, applies per-channel bias/ReLU/saturation, registers the result.
// Latency 1 cycle; acc_ready drops while the held output is stalled by out_ready.
module bias_channel_sequencer
  import bias_seq_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int ACC_W = DEF_ACC_W,
  parameter int PIX_W = DEF_PIX_W,
  parameter int SHIFT = DEF_SHIFT,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic        [PIX_W-1:0] num_pix,
  input  logic [N_CH-1:0][15:0]   bias_mem,
  input  logic                    acc_valid,
  input  logic signed [ACC_W-1:0] acc_data,
  output logic                    acc_ready,
  output logic                    out_valid,
  output logic        [15:0]      out_data,
  input  logic                    out_ready,
  output logic        [CH_W-1:0]  out_ch,
  output logic                    busy,
  output logic                    done
);

  seq_state_t       state, state_nxt;
  logic [CH_W-1:0]  ch_cnt;
  logic [PIX_W-1:0] pix_cnt;
  logic [PIX_W-1:0] num_pix_q;
  logic [15:0]      pp_result;
  logic             acc_fire;
  logic             last_ch;
  logic             last_pix;

  bias_postproc #(
    .ACC_W(ACC_W),
    .SHIFT(SHIFT)
  ) u_postproc (
    .acc_data(acc_data),
    .bias_sm (bias_mem[ch_cnt]),
    .result  (pp_result)
  );

  assign acc_ready = (state == ST_RUN) && (!out_valid || out_ready);
  assign acc_fire  = acc_valid && acc_ready;
  assign last_ch   = (ch_cnt == CH_W'(N_CH - 1));
  assign last_pix  = (pix_cnt == num_pix_q - PIX_W'(1));
  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (num_pix == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (acc_fire && last_ch && last_pix) state_nxt = ST_DRAIN;
      ST_DRAIN: if (out_valid && out_ready) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ch_cnt    <= '0;
      pix_cnt   <= '0;
      num_pix_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        ch_cnt    <= '0;
        pix_cnt   <= '0;
        num_pix_q <= num_pix;
      end else if (acc_fire) begin
        ch_cnt <= last_ch ? '0 : ch_cnt + CH_W'(1);
        if (last_ch) pix_cnt <= pix_cnt + PIX_W'(1);
      end
    end
  end

  // A new beat can only land when the register is empty or being drained this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (acc_fire) begin
      out_valid <= 1'b1;
      out_data  <= pp_result;
      out_ch    <= ch_cnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
